// File: rtl/sdram_tg_pkg.sv
// Shared definitions for the SDRAM traffic generator / checker.
// Holds the control FSM state encoding, the pattern mode encodings,
// the LFSR feedback polynomial and the error-counter width.
package sdram_tg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_CMD,
    WR_DATA,
    RD_CMD,
    RD_DATA,
    FIN
  } state_e;

  localparam logic [31:0] LFSR_POLY = 32'h80200003;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_LFSR = 1'b1;

  localparam int ERR_W = 16;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/sdram_tg_pattern.sv
// Deterministic data pattern source for the traffic checker.
// Ports:
//   clk   in  clock
//   mode  in  MODE_ADDR: data = addr ^ seed, MODE_LFSR: data = LFSR state
//   seed  in  pattern seed (a zero LFSR seed is replaced by 1)
//   load  in  reload the LFSR from seed
//   step  in  advance the LFSR by one beat
//   addr  in  word address of the beat the data output describes
//   data  out DW-bit pattern word
// The data output is look-ahead: it reflects the LFSR value after this
// cycle's load/step, so the caller can register it into its own output
// register on the same edge the beat is consumed.
module sdram_tg_pattern
  import sdram_tg_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 22
) (
  input  logic          clk,
  input  logic          mode,
  input  logic [31:0]   seed,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] data
);

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;
  logic [31:0] addr_ext;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = (seed == 32'd0) ? 32'd1 : seed;
    end else if (step) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk) begin
    lfsr_q <= lfsr_d;
  end

  always_comb begin
    addr_ext = 32'(addr);
    if (mode == MODE_LFSR) begin
      data = DW'(lfsr_d);
    end else begin
      data = DW'(addr_ext ^ seed);
    end
  end

endmodule

// File: rtl/sdram_traffic_checker.sv
// SDRAM traffic generator and read-back checker.
// Writes NB bursts of BL beats starting at base_addr with a deterministic
// pattern, reads them back and compares every beat.
// Ports:
//   clk, srst                  clock, synchronous active-high reset
//   start, mode, seed, base_addr   pass launch and its configuration
//   cmd_valid/cmd_ready/cmd_wr/cmd_addr   burst command handshake
//   wdata/wdata_ready          write beat, consumed when wdata_ready=1
//   rdata/rdata_valid          read beat from the controller
//   busy, done, pass, timeout  pass status (pass/timeout held until start)
//   err_cnt, first_err_addr    saturating mismatch count, first bad address
module sdram_traffic_checker
  import sdram_tg_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 22,
  parameter int BL = 8,
  parameter int NB = 4,
  parameter int TO = 1023
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             start,
  input  logic             mode,
  input  logic [31:0]      seed,
  input  logic [AW-1:0]    base_addr,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic             cmd_wr,
  output logic [AW-1:0]    cmd_addr,
  output logic [DW-1:0]    wdata,
  input  logic             wdata_ready,
  input  logic [DW-1:0]    rdata,
  input  logic             rdata_valid,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [ERR_W-1:0] err_cnt,
  output logic [AW-1:0]    first_err_addr
);

  localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int BTW = (BL > 1) ? $clog2(BL) : 1;
  localparam int TOW = (TO > 1) ? $clog2(TO) : 1;
  localparam logic [BW-1:0]  LAST_BURST = BW'(NB - 1);
  localparam logic [BTW-1:0] LAST_BEAT  = BTW'(BL - 1);
  localparam logic [TOW-1:0] TO_LAST    = TOW'(TO - 1);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  state_e           state_q, state_d;
  logic [BW-1:0]    burst_q, burst_d;
  logic [BTW-1:0]   beat_q, beat_d;
  logic [TOW-1:0]   to_cnt_q, to_cnt_d;
  logic             mode_q, mode_d;
  logic [31:0]      seed_q, seed_d;
  logic [AW-1:0]    base_q, base_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             cmd_wr_q, cmd_wr_d;
  logic [AW-1:0]    cmd_addr_q, cmd_addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [DW-1:0]    exp_q, exp_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [AW-1:0]    first_err_addr_q, first_err_addr_d;
  logic             err_seen_q, err_seen_d;
  logic             vld_p1_q, vld_p1_d;
  logic             mism_p1_q, mism_p1_d;
  logic             spur_p1_q, spur_p1_d;
  logic [AW-1:0]    addr_p1_q, addr_p1_d;

  logic             wload, wstep, rload, rstep;
  logic [AW-1:0]    wpat_addr, rpat_addr, next_beat_addr;
  logic [DW-1:0]    wpat_data, rpat_data;

  sdram_tg_pattern #(.DW(DW), .AW(AW)) u_wr_pat (
    .clk  (clk),
    .mode (mode_q),
    .seed (seed_q),
    .load (wload),
    .step (wstep),
    .addr (wpat_addr),
    .data (wpat_data)
  );

  sdram_tg_pattern #(.DW(DW), .AW(AW)) u_rd_pat (
    .clk  (clk),
    .mode (mode_q),
    .seed (seed_q),
    .load (rload),
    .step (rstep),
    .addr (rpat_addr),
    .data (rpat_data)
  );

  always_comb begin
    state_d          = state_q;
    burst_d          = burst_q;
    beat_d           = beat_q;
    to_cnt_d         = to_cnt_q;
    mode_d           = mode_q;
    seed_d           = seed_q;
    base_d           = base_q;
    cmd_valid_d      = cmd_valid_q;
    cmd_wr_d         = cmd_wr_q;
    cmd_addr_d       = cmd_addr_q;
    wdata_d          = wdata_q;
    exp_d            = exp_q;
    busy_d           = busy_q;
    done_d           = 1'b0;
    pass_d           = pass_q;
    timeout_d        = timeout_q;
    err_cnt_d        = err_cnt_q;
    first_err_addr_d = first_err_addr_q;
    err_seen_d       = err_seen_q;
    vld_p1_d         = 1'b0;
    mism_p1_d        = 1'b0;
    spur_p1_d        = 1'b0;
    addr_p1_d        = addr_p1_q;
    wload            = 1'b0;
    wstep            = 1'b0;
    rload            = 1'b0;
    rstep            = 1'b0;
    next_beat_addr   = cmd_addr_q + AW'(beat_q) + AW'(1);
    wpat_addr        = next_beat_addr;
    rpat_addr        = next_beat_addr;

    // ---- stage p1: retire the registered compare result ----
    if (vld_p1_q && mism_p1_q) begin
      err_cnt_d = sat_inc(err_cnt_q);
      if (!spur_p1_q && !err_seen_q) begin
        first_err_addr_d = addr_p1_q;
        err_seen_d       = 1'b1;
      end
    end

    // ---- stage p0: capture compare of the incoming read beat ----
    if (rdata_valid && (state_q != RD_DATA)) begin
      vld_p1_d  = 1'b1;
      mism_p1_d = 1'b1;
      spur_p1_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d           = mode;
          seed_d           = seed;
          base_d           = base_addr;
          err_cnt_d        = '0;
          first_err_addr_d = '0;
          err_seen_d       = 1'b0;
          pass_d           = 1'b0;
          timeout_d        = 1'b0;
          burst_d          = '0;
          beat_d           = '0;
          busy_d           = 1'b1;
          cmd_valid_d      = 1'b1;
          cmd_wr_d         = 1'b1;
          cmd_addr_d       = base_addr;
          state_d          = WR_CMD;
        end
      end

      WR_CMD: begin
        // Only the first burst reloads; later bursts continue the sequence.
        wload     = (burst_q == '0);
        wpat_addr = cmd_addr_q;
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          wdata_d     = wpat_data;
          beat_d      = '0;
          state_d     = WR_DATA;
        end
      end

      WR_DATA: begin
        if (wdata_ready) begin
          wstep   = 1'b1;
          wdata_d = wpat_data;
          if (beat_q == LAST_BEAT) begin
            beat_d      = '0;
            cmd_valid_d = 1'b1;
            if (burst_q != LAST_BURST) begin
              burst_d    = burst_q + 1'b1;
              cmd_addr_d = cmd_addr_q + AW'(BL);
              cmd_wr_d   = 1'b1;
              state_d    = WR_CMD;
            end else begin
              burst_d    = '0;
              cmd_addr_d = base_q;
              cmd_wr_d   = 1'b0;
              state_d    = RD_CMD;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      RD_CMD: begin
        rload     = (burst_q == '0);
        rpat_addr = cmd_addr_q;
        to_cnt_d  = '0;
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          exp_d       = rpat_data;
          beat_d      = '0;
          state_d     = RD_DATA;
        end
      end

      RD_DATA: begin
        if (rdata_valid) begin
          rstep     = 1'b1;
          exp_d     = rpat_data;
          to_cnt_d  = '0;
          vld_p1_d  = 1'b1;
          mism_p1_d = (rdata != exp_q);
          addr_p1_d = cmd_addr_q + AW'(beat_q);
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            if (burst_q != LAST_BURST) begin
              burst_d     = burst_q + 1'b1;
              cmd_addr_d  = cmd_addr_q + AW'(BL);
              cmd_valid_d = 1'b1;
              cmd_wr_d    = 1'b0;
              state_d     = RD_CMD;
            end else begin
              state_d = FIN;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end else if (to_cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = FIN;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      FIN: begin
        // Hold until the final compare has landed in err_cnt.
        if (!vld_p1_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_cnt_q == '0) && !timeout_q;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q          <= IDLE;
      burst_q          <= '0;
      beat_q           <= '0;
      to_cnt_q         <= '0;
      cmd_valid_q      <= 1'b0;
      cmd_wr_q         <= 1'b0;
      cmd_addr_q       <= '0;
      wdata_q          <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      timeout_q        <= 1'b0;
      err_cnt_q        <= '0;
      first_err_addr_q <= '0;
      err_seen_q       <= 1'b0;
      vld_p1_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      burst_q          <= burst_d;
      beat_q           <= beat_d;
      to_cnt_q         <= to_cnt_d;
      cmd_valid_q      <= cmd_valid_d;
      cmd_wr_q         <= cmd_wr_d;
      cmd_addr_q       <= cmd_addr_d;
      wdata_q          <= wdata_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
      timeout_q        <= timeout_d;
      err_cnt_q        <= err_cnt_d;
      first_err_addr_q <= first_err_addr_d;
      err_seen_q       <= err_seen_d;
      vld_p1_q         <= vld_p1_d;
    end
  end

  always_ff @(posedge clk) begin
    mode_q    <= mode_d;
    seed_q    <= seed_d;
    base_q    <= base_d;
    exp_q     <= exp_d;
    mism_p1_q <= mism_p1_d;
    spur_p1_q <= spur_p1_d;
    addr_p1_q <= addr_p1_d;
  end

  assign cmd_valid      = cmd_valid_q;
  assign cmd_wr         = cmd_wr_q;
  assign cmd_addr       = cmd_addr_q;
  assign wdata          = wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign timeout        = timeout_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_addr_q;

endmodule

// File: tb/tb_sdram_traffic_checker.sv
module tb_sdram_traffic_checker;

  localparam int DW = 16;
  localparam int AW = 22;
  localparam int BL = 8;
  localparam int NB = 4;
  localparam int TO = 1023;

  typedef struct packed { logic wr; logic [AW-1:0] addr; } cmd_t;
  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } beat_t;
  typedef struct packed {
    logic ps; logic to; logic [15:0] ec; logic [AW-1:0] fa;
  } res_t;

  logic          clk = 1'b0;
  logic          srst, start, mode;
  logic [31:0]   seed;
  logic [AW-1:0] base_addr;
  logic          cmd_valid, cmd_ready, cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] wdata, rdata;
  logic          wdata_ready, rdata_valid;
  logic          busy, done, pass, timeout;
  logic [15:0]   err_cnt;
  logic [AW-1:0] first_err_addr;

  int n_cmp = 0;
  int n_fail = 0;

  cmd_t  cmd_q[$];
  beat_t wq[$];
  res_t  res_q[$];

  // responder controls
  bit stall_en = 0;
  int sup_after = -1;
  int flt_idx = -1;
  bit spur_req = 0;

  logic [DW-1:0] mem [logic [AW-1:0]];

  always #5 clk = ~clk;

  sdram_traffic_checker #(.DW(DW), .AW(AW), .BL(BL), .NB(NB), .TO(TO)) dut (
    .clk(clk), .srst(srst), .start(start), .mode(mode), .seed(seed),
    .base_addr(base_addr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .wdata(wdata),
    .wdata_ready(wdata_ready), .rdata(rdata), .rdata_valid(rdata_valid),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_cnt(err_cnt), .first_err_addr(first_err_addr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s", nm);
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'h80200003;
    return r;
  endfunction

  // SDRAM-side responder: decides this cycle's inputs at the falling edge.
  initial begin : responder
    logic [AW-1:0] wr_addr, rd_addr;
    int wr_left, rd_left, rd_idx;
    cmd_ready = 0; wdata_ready = 0; rdata_valid = 0; rdata = '0;
    wr_addr = '0; rd_addr = '0; wr_left = 0; rd_left = 0; rd_idx = 0;
    forever begin
      @(negedge clk);
      if (srst || done) begin
        wr_left = 0; rd_left = 0; rd_idx = 0;
      end
      wdata_ready = 1'b0;
      if (wr_left > 0 && (!stall_en || $urandom_range(0, 2) != 0)) begin
        wdata_ready = 1'b1;
        mem[wr_addr] = wdata;
        wr_addr = wr_addr + 1'b1;
        wr_left--;
      end
      rdata_valid = 1'b0;
      rdata = '0;
      if (spur_req) begin
        rdata_valid = 1'b1;
        spur_req = 0;
      end else if (rd_left > 0 && !(sup_after >= 0 && rd_idx >= sup_after) &&
                   (!stall_en || $urandom_range(0, 2) != 0)) begin
        rdata_valid = 1'b1;
        rdata = mem.exists(rd_addr) ? mem[rd_addr] : '0;
        if (rd_idx == flt_idx) rdata = rdata ^ 16'h0008;
        rd_addr = rd_addr + 1'b1;
        rd_left--;
        rd_idx++;
      end
      cmd_ready = !stall_en || ($urandom_range(0, 2) != 0);
      if (cmd_valid && cmd_ready && !srst) begin
        if (cmd_wr) begin wr_left = BL; wr_addr = cmd_addr; end
        else        begin rd_left = BL; rd_addr = cmd_addr; end
      end
    end
  end

  // Scoreboard monitor: pops expectations whenever the DUT presents something.
  initial begin : monitor
    cmd_t c; beat_t b; res_t r;
    forever begin
      @(negedge clk);
      #2;
      if (!srst) begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_q.size() == 0) fail_now("cmd_unexpected");
          else begin
            c = cmd_q.pop_front();
            chk("cmd_wr", 32'(cmd_wr), 32'(c.wr));
            chk("cmd_addr", 32'(cmd_addr), 32'(c.addr));
          end
        end
        if (wdata_ready) begin
          if (wq.size() == 0) fail_now("wbeat_unexpected");
          else begin
            b = wq.pop_front();
            chk($sformatf("wdata@%0h", b.addr), 32'(wdata), 32'(b.data));
          end
        end
        if (done) begin
          if (res_q.size() == 0) fail_now("done_unexpected");
          else begin
            r = res_q.pop_front();
            chk("pass", 32'(pass), 32'(r.ps));
            chk("timeout", 32'(timeout), 32'(r.to));
            chk("err_cnt", 32'(err_cnt), 32'(r.ec));
            chk("first_err_addr", 32'(first_err_addr), 32'(r.fa));
            chk("busy_at_done", 32'(busy), 32'd0);
            chk("cmds_left", 32'(cmd_q.size()), 32'd0);
            chk("wbeats_left", 32'(wq.size()), 32'd0);
          end
        end
      end
    end
  end

  task automatic push_expect(input logic md, input logic [31:0] sd, input logic [AW-1:0] base,
                             input int rd_bursts);
    logic [31:0] s, mix;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] hand [3];
    hand[0] = 16'hACE1; hand[1] = 16'h5673; hand[2] = 16'h2B3A;
    s = (sd == 0) ? 32'd1 : sd;
    for (int b = 0; b < NB; b++) cmd_q.push_back('{1'b1, base + AW'(b * BL)});
    for (int b = 0; b < rd_bursts; b++) cmd_q.push_back('{1'b0, base + AW'(b * BL)});
    for (int k = 0; k < NB * BL; k++) begin
      a = base + AW'(k);
      mix = 32'(a) ^ sd;
      d = md ? s[DW-1:0] : mix[DW-1:0];
      if (md && sd == 32'hACE1 && k < 3) d = hand[k];
      wq.push_back('{a, d});
      s = lfsr_step(s);
    end
  endtask

  task automatic run_pass(input logic md, input logic [31:0] sd, input logic [AW-1:0] base,
                          input int rd_bursts, input res_t exp_r, input bit poke,
                          output int lat);
    bit got;
    push_expect(md, sd, base, rd_bursts);
    res_q.push_back(exp_r);
    @(negedge clk);
    mode = md; seed = sd; base_addr = base; start = 1'b1;
    lat = 0; got = 0;
    while (!got && lat < 3000) begin
      @(negedge clk);
      lat++;
      start = poke && (lat == 10);
      if (start) begin mode = ~md; seed = 32'hFFFF; base_addr = '0; end
      if (lat == 1) chk("busy_rise", 32'(busy), 32'd1);
      if (done) got = 1;
    end
    start = 1'b0;
    if (!got) fail_now("done_wait expired");
    @(negedge clk);
  endtask

  task automatic chk_reset_state();
    chk("rst_cmd_valid", 32'(cmd_valid), 0);
    chk("rst_cmd_wr", 32'(cmd_wr), 0);
    chk("rst_cmd_addr", 32'(cmd_addr), 0);
    chk("rst_wdata", 32'(wdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_first_err_addr", 32'(first_err_addr), 0);
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "simulation time limit");
  end

  initial begin : stim
    int lat;
    srst = 1'b1; start = 1'b0; mode = 1'b0; seed = '0; base_addr = '0;
    repeat (3) @(negedge clk);
    chk_reset_state();
    srst = 1'b0;

    // basic address pattern, plus a start pulse while busy that must be ignored
    run_pass(1'b0, 32'd0, 22'h000100, NB, '{1'b1, 1'b0, 16'd0, 22'd0}, 1'b1, lat);
    chk("pass_len_min", 32'(lat >= 75), 32'd1);

    // spurious read beat while idle: one error, no address capture
    spur_req = 1;
    repeat (4) @(negedge clk);
    chk("spur_err_cnt", 32'(err_cnt), 32'd1);
    chk("spur_first_err_addr", 32'(first_err_addr), 32'd0);
    chk("spur_pass_held", 32'(pass), 32'd1);

    // LFSR pattern
    run_pass(1'b1, 32'h0000ACE1, 22'h000100, NB, '{1'b1, 1'b0, 16'd0, 22'd0}, 1'b0, lat);

    // bit 3 flipped on 5th beat of burst 2 -> address base+0x14
    flt_idx = 2 * BL + 4;
    run_pass(1'b0, 32'h00001234, 22'h000100, NB, '{1'b0, 1'b0, 16'd1, 22'h000114}, 1'b0, lat);
    flt_idx = -1;

    // random stalls and address wrap past the top
    stall_en = 1;
    run_pass(1'b1, 32'h00000000, 22'h3FFFFC, NB, '{1'b1, 1'b0, 16'd0, 22'd0}, 1'b0, lat);
    stall_en = 0;

    // read data stops after 3 beats of burst 0
    sup_after = 3;
    run_pass(1'b0, 32'h0000BEEF, 22'h000200, 1, '{1'b0, 1'b1, 16'd0, 22'd0}, 1'b0, lat);
    sup_after = -1;

    // reset during WR_DATA, then a clean pass
    push_expect(1'b1, 32'h00005A5A, 22'h000040, NB);
    @(negedge clk);
    mode = 1'b1; seed = 32'h00005A5A; base_addr = 22'h000040; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    srst = 1'b1;
    cmd_q.delete(); wq.delete();
    repeat (2) @(negedge clk);
    #1;
    chk_reset_state();
    @(negedge clk);
    srst = 1'b0;
    run_pass(1'b1, 32'h00005A5A, 22'h000040, NB, '{1'b1, 1'b0, 16'd0, 22'd0}, 1'b0, lat);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_traffic_checker.md
# sdram_traffic_checker

Parametrised, synthesizable traffic generator and data checker that drives the user-side command/data port of the SDRAM controller. It writes a configurable number of bursts with a deterministic pattern, reads them back, and compares beat by beat. It reports pass/fail, an error count and the first failing address. It sits beside the controller in the top-level, for both simulation against the SDRAM model and on-board self-test.

## Interface
Parameters:
- DW, 16: data width, 1..32.
- AW, 22: user word-address width (bank+row+column).
- BL, 8: beats per burst, power of two, 1..256.
- NB, 4: bursts per pass, 1..1024.
- TO, 1023: read-timeout cycles per burst.

Ports:
- clk  in  1  system clock.
- srst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle pulse; begins a pass when idle.
- mode  in  1  0 = address pattern, 1 = LFSR pattern; sampled at start.
- seed  in  32  pattern seed; sampled at start.
- base_addr  in  AW  first burst address; sampled at start.
- cmd_valid  out  1  command request.
- cmd_ready  in  1  controller accepts command.
- cmd_wr  out  1  1 = write, 0 = read.
- cmd_addr  out  AW  burst start address.
- wdata  out  DW  write beat.
- wdata_ready  in  1  controller consumes wdata this cycle.
- rdata  in  DW  read beat.
- rdata_valid  in  1  rdata valid.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse at end of pass.
- pass  out  1  result of last pass; held until next start.
- timeout  out  1  last pass aborted on timeout; held until next start.
- err_cnt  out  16  mismatching beats, saturating.
- first_err_addr  out  AW  address of first mismatch.

## Operation
- FSM states: IDLE, WR_CMD, WR_DATA, RD_CMD, RD_DATA, FIN.
- IDLE:
  - start latches mode, seed and base_addr.
  - Clears err_cnt, first_err_addr, pass and timeout.
  - Moves to WR_CMD.
- WR_CMD:
  - cmd_valid=1, cmd_wr=1, cmd_addr = base_addr + b·BL, where b is the burst index.
  - On cmd_ready, moves to WR_DATA.
- WR_DATA:
  - Each wdata_ready cycle advances the beat counter and the pattern.
  - After BL beats: b+1 < NB goes to WR_CMD; otherwise b is reset to 0 and the FSM goes to RD_CMD.
- RD_CMD: same as WR_CMD with cmd_wr=0; then RD_DATA.
- RD_DATA:
  - Each rdata_valid beat is compared against the regenerated expected pattern.
  - After BL beats, goes to the next RD_CMD or to FIN.
- FIN:
  - done=1 for one cycle.
  - pass = (err_cnt==0 && !timeout).
  - Returns to IDLE.
- Pattern for beat address a:
  - mode 0: data = (a ^ seed)[DW-1:0].
  - mode 1: 32-bit Galois LFSR, polynomial 0x80200003, loaded with seed (0 replaced by 1). It steps once per beat, and data = lfsr[DW-1:0].
  - The read phase reloads the seed and regenerates the identical sequence.
- Address arithmetic is modulo 2^AW; wrap past the top is legal and silent.
- Mismatch handling:
  - Each mismatch increments err_cnt, saturating at 0xFFFF.
  - first_err_addr is captured on the first mismatch only.
- Spurious rdata_valid outside RD_DATA counts as one error with no address capture.
- start while busy is ignored.
- Timeout: in RD_DATA, a counter resets on each rdata_valid. If it reaches TO, the FSM sets timeout=1 and goes to FIN.
- srst at any time: FSM to IDLE, all outputs to reset values, in-flight beats discarded.

## Timing
- Reset values: cmd_valid 0, cmd_wr 0, cmd_addr 0, wdata 0, busy 0, done 0, pass 0, timeout 0, err_cnt 0, first_err_addr 0.
- All outputs are registered.
- busy rises the cycle after start and falls the cycle done pulses.
- cmd_valid holds, with stable cmd_wr and cmd_addr, until the cycle cmd_ready=1. It deasserts the following cycle.
- wdata shows beat 0 from the cycle WR_DATA is entered. It changes only the cycle after a wdata_ready, with zero bubble between beats.
- Compare is pipelined one stage: err_cnt and first_err_addr update one cycle after the failing rdata_valid.
- FIN waits for the last compare to retire before pulsing done.
- Minimum pass length: 2·NB·(BL+1)+3 cycles with cmd_ready, wdata_ready and rdata_valid always high.

## Structure
- Shared package sdram_tg_pkg holds:
  - state enum;
  - LFSR polynomial constant 32'h80200003;
  - mode encodings;
  - err_cnt width 16.
- One sub-module, sdram_tg_pattern (pattern generator):
  - inputs: mode, seed, load, step, beat address;
  - output: DW-bit data.
  - Two instances: write-side and read-side.

## Test plan
- Basic pass: DW=16, BL=8, NB=4, mode 0, seed 0, base 0x000100, all readies high against the SDRAM model → done after ≥75 cycles, pass=1, err_cnt=0.
- LFSR pass: mode 1, seed 0xACE1 → write beats follow the LFSR sequence, readback matches, pass=1.
- Injected fault: force rdata bit 3 on the 5th beat of burst 2 → err_cnt=1, first_err_addr=base+0x14, pass=0.
- Backpressure and wrap: random cmd_ready/wdata_ready stalls, base_addr=2^AW−4 → cmd_addr wraps to 0x000004 on burst 1, no beat dropped or duplicated, pass=1.
- Timeout: suppress rdata_valid after 3 beats of burst 0 → timeout=1 after TO=1023 idle cycles, done pulses, pass=0.
- Reset mid-pass: assert srst during WR_DATA, then start again → all outputs at reset values, second pass completes with pass=1.
